// File: rtl/times_divider.sv
// times_divider: sequential restoring divider, one quotient bit per enabled clock.
// Latency: done pulses DIVIDEND_W enabled edges after the accepting edge; a zero
//          divisor completes on the first enabled edge after acceptance.
// Backpressure: enable=0 freezes the FSM and datapath; start is ignored while busy.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   enable              - 1 = advance, 0 = hold all working state
//   start               - request, taken only when busy=0 and enable=1
//   dividend, divisor   - operands, captured on an accepted start
//   quotient, remainder - registered results, held until the next completion
//   busy                - operation in flight
//   done                - one-cycle pulse when the results update
//   div_by_zero         - registered flag, valid with done, held with the results
module times_divider #(
    parameter int DIVIDEND_W = 6,
    parameter int DIVISOR_W  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero
);

    localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CALC = 1'b1
    } state_t;

    // Registered state
    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DIVIDEND_W-1:0] r_dvd;
    logic [DIVISOR_W-1:0]  r_dvs;
    logic [DIVISOR_W:0]    r_prem;    // partial remainder, one bit wider than divisor
    logic [DIVIDEND_W-1:0] r_pquo;    // partial quotient, shifted in MSB first
    logic [DIVIDEND_W-1:0] r_quo;
    logic [DIVISOR_W-1:0]  r_rem;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_dbz;

    // Next-state values
    state_t                w_state;
    logic [CNT_W-1:0]      w_cnt;
    logic [DIVIDEND_W-1:0] w_dvd;
    logic [DIVISOR_W-1:0]  w_dvs;
    logic [DIVISOR_W:0]    w_prem;
    logic [DIVIDEND_W-1:0] w_pquo;
    logic [DIVIDEND_W-1:0] w_quo;
    logic [DIVISOR_W-1:0]  w_rem;
    logic                  w_busy;
    logic                  w_done;
    logic                  w_dbz;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    logic [DIVISOR_W:0]    w_shift;
    logic [DIVISOR_W:0]    w_dvs_ext;
    logic                  w_fits;
    logic [DIVISOR_W:0]    w_step_rem;
    logic [DIVIDEND_W-1:0] w_step_quo;

    assign w_shift    = {r_prem[DIVISOR_W-1:0], r_dvd[r_cnt]};
    assign w_dvs_ext  = {1'b0, r_dvs};
    assign w_fits     = (w_shift >= w_dvs_ext);
    assign w_step_rem = w_fits ? (w_shift - w_dvs_ext) : w_shift;
    assign w_step_quo = {r_pquo[DIVIDEND_W-2:0], w_fits};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_prem  <= '0;
            r_pquo  <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_dvd   <= w_dvd;
            r_dvs   <= w_dvs;
            r_prem  <= w_prem;
            r_pquo  <= w_pquo;
            r_quo   <= w_quo;
            r_rem   <= w_rem;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_dbz   <= w_dbz;
        end
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_dvd   = r_dvd;
        w_dvs   = r_dvs;
        w_prem  = r_prem;
        w_pquo  = r_pquo;
        w_quo   = r_quo;
        w_rem   = r_rem;
        w_busy  = r_busy;
        w_done  = 1'b0;           // done is a pulse: drops on every edge not completing
        w_dbz   = r_dbz;

        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    if (r_busy) begin
                        // Busy while IDLE only happens after accepting a zero
                        // divisor: report the saturated result one edge later.
                        w_busy = 1'b0;
                        w_done = 1'b1;
                        w_dbz  = 1'b1;
                        w_quo  = '1;
                        w_rem  = '0;
                    end else if (start) begin
                        w_dvd  = dividend;
                        w_dvs  = divisor;
                        w_busy = 1'b1;
                        w_prem = '0;
                        w_pquo = '0;
                        w_cnt  = CNT_W'(DIVIDEND_W - 1);
                        if (divisor != '0) begin
                            w_state = S_CALC;
                        end
                    end
                end
            end

            S_CALC: begin
                if (enable) begin
                    w_prem = w_step_rem;
                    w_pquo = w_step_quo;
                    if (r_cnt == '0) begin
                        w_state = S_IDLE;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                        w_dbz   = 1'b0;
                        w_quo   = w_step_quo;
                        w_rem   = w_step_rem[DIVISOR_W-1:0];
                    end else begin
                        w_cnt = r_cnt - CNT_W'(1);
                    end
                end
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign quotient    = r_quo;
    assign remainder   = r_rem;
    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_times_divider.sv
// tb_times_divider: randomized and directed stimulus for times_divider, checked
// against a plain integer-division reference (a/b, a%b, saturated on b==0) with
// latency, busy, done-pulse and hold-behaviour expectations.
module tb_times_divider;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       start;
    logic [5:0] dividend;
    logic [2:0] divisor;
    logic [5:0] quotient;
    logic [2:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    int vectors     = 0;
    int miscompares = 0;
    int last_q      = 0;
    int last_r      = 0;
    int last_z      = 0;

    always #5 clk = ~clk;

    times_divider #(.DIVIDEND_W(6), .DIVISOR_W(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit stalled(input int edge_idx, input int stall_at, input int stall_len);
        return (stall_len > 0) && (edge_idx > stall_at) && (edge_idx <= stall_at + stall_len);
    endfunction

    // Issue one operation from a negedge; returns on the negedge where done is seen.
    // A spurious start with other operands is injected while the operation is busy.
    task automatic run_op(input int a, input int b, input int stall_at, input int stall_len);
        int exp_q;
        int exp_r;
        int exp_lat;
        int n;
        bit got_done;
        exp_q   = (b == 0) ? 63 : a / b;
        exp_r   = (b == 0) ? 0 : a % b;
        exp_lat = (b == 0) ? 1 : 6 + stall_len;

        dividend = 6'(a);
        divisor  = 3'(b);
        start    = 1'b1;
        enable   = 1'b1;
        @(posedge clk);                 // accepting edge E0
        @(negedge clk);
        start = 1'b0;
        check("busy_after_accept", busy, 1);
        check("done_not_early", done, 0);
        enable = !stalled(1, stall_at, stall_len);

        n = 0;
        got_done = 1'b0;
        while (n < 40 && !got_done) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) begin
                got_done = 1'b1;
            end else begin
                check("busy_in_flight", busy, 1);
                enable = !stalled(n + 1, stall_at, stall_len);
                if (n == 2) begin
                    start    = 1'b1;
                    dividend = 6'd9;
                    divisor  = 3'd3;
                end else begin
                    start = 1'b0;
                end
            end
        end
        start  = 1'b0;
        enable = 1'b1;

        check("done_seen", got_done, 1);
        check("latency", n, exp_lat);
        check("quotient", quotient, exp_q);
        check("remainder", remainder, exp_r);
        check("div_by_zero", div_by_zero, (b == 0) ? 1 : 0);
        check("busy_at_done", busy, 0);
        last_q = exp_q;
        last_r = exp_r;
        last_z = (b == 0) ? 1 : 0;
    endtask

    // Idle cycles: done must have dropped and the results must hold.
    task automatic gap(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("done_pulse_drop", done, 0);
            check("hold_quotient", quotient, last_q);
            check("hold_remainder", remainder, last_r);
            check("hold_dbz", div_by_zero, last_z);
        end
    endtask

    initial begin
        bit seen_done;
        rst_n    = 1'b0;
        enable   = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", div_by_zero, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        run_op(49, 7, 0, 0);
        gap(2);
        run_op(63, 5, 0, 0);
        run_op(0, 3, 0, 0);             // start issued in the done cycle
        gap(1);
        run_op(20, 0, 0, 0);
        gap(1);
        run_op(20, 4, 0, 0);            // valid divide clears div_by_zero
        gap(1);
        run_op(42, 6, 2, 3);            // 3 stalled edges mid-calculation
        gap(1);

        // start with enable low is ignored
        enable   = 1'b0;
        start    = 1'b1;
        dividend = 6'd11;
        divisor  = 3'd2;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("en_low_busy", busy, 0);
            check("en_low_done", done, 0);
        end
        start  = 1'b0;
        enable = 1'b1;
        gap(2);

        // Reset in the middle of an operation
        dividend = 6'd50;
        divisor  = 3'd7;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("no_done_after_abort", seen_done, 0);
        run_op(50, 7, 0, 0);
        gap(1);

        // Exhaustive sweep, back-to-back
        for (int a = 0; a < 64; a++) begin
            for (int b = 1; b < 8; b++) begin
                run_op(a, b, 0, 0);
                check("inv_qd_plus_r", int'(quotient) * b + int'(remainder), a);
                check("inv_r_lt_d", (int'(remainder) < b) ? 1 : 0, 1);
            end
        end
        gap(1);

        // Randomized operations with random stalls and gaps
        for (int i = 0; i < 150; i++) begin
            int a;
            int b;
            a = int'($urandom_range(0, 63));
            b = int'($urandom_range(0, 7));
            run_op(a, b, int'($urandom_range(1, 4)), int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) gap(int'($urandom_range(1, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
